branch_target_buffer: RTL and testbench

Parametrised branch target buffer that serves the fetch stage. It generalises the current single-purpose BTB hookup to a configurable direct-mapped table with tag compare, 2-bit saturating direction counters, a resolve-time update port and a full flush. Fetch presents the current PC and gets hit/predicted-PC in the same cycle. The execute stage writes back resolved branch outcomes.

---
 rtl/branch_target_buffer_pkg.sv | 28 ++
 rtl/branch_target_buffer_entry_array.sv | 66 ++++++
 rtl/branch_target_buffer.sv | 58 +++++
 tb/tb_branch_target_buffer.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/branch_target_buffer_pkg.sv
// Shared BTB types: entry layout, direction-counter encodings and saturating helpers.
// Lookup/update modules import only the items they need so their own PC_WIDTH/ENTRY_NUM parameters stay local.
package BtbTypes;
   localparam int PC_WIDTH    = 32;
   localparam int ENTRY_NUM   = 16;
   localparam int INDEX_WIDTH = $clog2(ENTRY_NUM);
   localparam int TAG_WIDTH   = PC_WIDTH - INDEX_WIDTH - 2;

   localparam logic [1:0] STRONG_NT = 2'b00;
   localparam logic [1:0] WEAK_NT   = 2'b01;
   localparam logic [1:0] WEAK_T    = 2'b10;
   localparam logic [1:0] STRONG_T  = 2'b11;

   typedef struct packed {
      logic                 valid;
      logic [TAG_WIDTH-1:0] tag;
      logic [PC_WIDTH-3:0]  target;
      logic [1:0]           ctr;
   } BtbEntry;

   function automatic logic [1:0] satInc(input logic [1:0] c);
      return (c == STRONG_T) ? STRONG_T : c + 2'b01;
   endfunction

   function automatic logic [1:0] satDec(input logic [1:0] c);
      return (c == STRONG_NT) ? STRONG_NT : c - 2'b01;
   endfunction
endpackage

// File: rtl/branch_target_buffer_entry_array.sv
// Direct-mapped BTB storage with one resolve-time write port and one combinational read port.
// Flush dominates a simultaneous write; only valid and ctr are reset, tag/target are plain storage.
module btb_entry_array
   import BtbTypes::satInc, BtbTypes::satDec, BtbTypes::WEAK_T, BtbTypes::STRONG_NT;
#(
   parameter int PC_WIDTH    = 32,
   parameter int ENTRY_NUM   = 16,
   parameter int INDEX_WIDTH = $clog2(ENTRY_NUM),
   parameter int TAG_WIDTH   = PC_WIDTH - INDEX_WIDTH - 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   i_flush,
   input  logic                   i_wr_en,
   input  logic [INDEX_WIDTH-1:0] i_wr_idx,
   input  logic [TAG_WIDTH-1:0]   i_wr_tag,
   input  logic [PC_WIDTH-3:0]    i_wr_target,
   input  logic                   i_wr_taken,
   input  logic [INDEX_WIDTH-1:0] i_rd_idx,
   output logic                   o_rd_valid,
   output logic [TAG_WIDTH-1:0]   o_rd_tag,
   output logic [PC_WIDTH-3:0]    o_rd_target,
   output logic [1:0]             o_rd_ctr,
   output logic [ENTRY_NUM-1:0]   o_valid
);
   logic [ENTRY_NUM-1:0] r_valid;
   logic [TAG_WIDTH-1:0] r_tag    [ENTRY_NUM];
   logic [PC_WIDTH-3:0]  r_target [ENTRY_NUM];
   logic [1:0]           r_ctr    [ENTRY_NUM];

   logic w_wr_hit;
   logic w_alloc;
   logic w_train;

   assign w_wr_hit = r_valid[i_wr_idx] && (r_tag[i_wr_idx] == i_wr_tag);
   // A not-taken miss leaves the current occupant alone.
   assign w_alloc  = i_wr_en && !i_flush && !w_wr_hit && i_wr_taken;
   assign w_train  = i_wr_en && !i_flush && w_wr_hit;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid <= '0;
         for (int i = 0; i < ENTRY_NUM; i++) r_ctr[i] <= STRONG_NT;
      end else if (i_flush) begin
         r_valid <= '0;
      end else if (w_alloc) begin
         r_valid[i_wr_idx] <= 1'b1;
         r_ctr[i_wr_idx]   <= WEAK_T;
      end else if (w_train) begin
         r_ctr[i_wr_idx] <= i_wr_taken ? satInc(r_ctr[i_wr_idx]) : satDec(r_ctr[i_wr_idx]);
      end
   end

   always_ff @(posedge clk) begin
      if (w_alloc || (w_train && i_wr_taken)) begin
         r_tag[i_wr_idx]    <= i_wr_tag;
         r_target[i_wr_idx] <= i_wr_target;
      end
   end

   assign o_rd_valid  = r_valid[i_rd_idx];
   assign o_rd_tag    = r_tag[i_rd_idx];
   assign o_rd_target = r_target[i_rd_idx];
   assign o_rd_ctr    = r_ctr[i_rd_idx];
   assign o_valid     = r_valid;
endmodule

// File: rtl/branch_target_buffer.sv
// Fetch-side BTB: zero-latency lookup of pc against a direct-mapped table trained by execute.
// Lookup sees pre-update contents when it collides with a same-cycle write.
module branch_target_buffer
   import BtbTypes::WEAK_T;
#(
   parameter int PC_WIDTH    = 32,
   parameter int ENTRY_NUM   = 16,
   localparam int INDEX_WIDTH = $clog2(ENTRY_NUM),
   localparam int TAG_WIDTH   = PC_WIDTH - INDEX_WIDTH - 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [PC_WIDTH-1:0]  pc,
   output logic                 btbHit,
   output logic [PC_WIDTH-1:0]  btbPredictedPc,
   input  logic                 updateEn,
   input  logic [PC_WIDTH-1:0]  updatePc,
   input  logic                 updateTaken,
   input  logic [PC_WIDTH-1:0]  updateTarget,
   input  logic                 flushAll,
   output logic [ENTRY_NUM-1:0] valid
);
   logic                   w_rd_valid;
   logic [TAG_WIDTH-1:0]   w_rd_tag;
   logic [PC_WIDTH-3:0]    w_rd_target;
   logic [1:0]             w_rd_ctr;
   logic                   w_tag_match;
   logic                   w_unused_lsbs;

   // PCs are word aligned; the low two bits carry no information.
   assign w_unused_lsbs = ^{pc[1:0], updatePc[1:0], updateTarget[1:0]};

   btb_entry_array #(
      .PC_WIDTH   (PC_WIDTH),
      .ENTRY_NUM  (ENTRY_NUM),
      .INDEX_WIDTH(INDEX_WIDTH),
      .TAG_WIDTH  (TAG_WIDTH)
   ) u_array (
      .clk        (clk),
      .rst        (rst),
      .i_flush    (flushAll),
      .i_wr_en    (updateEn),
      .i_wr_idx   (updatePc[INDEX_WIDTH+1:2]),
      .i_wr_tag   (updatePc[PC_WIDTH-1:INDEX_WIDTH+2]),
      .i_wr_target(updateTarget[PC_WIDTH-1:2]),
      .i_wr_taken (updateTaken),
      .i_rd_idx   (pc[INDEX_WIDTH+1:2]),
      .o_rd_valid (w_rd_valid),
      .o_rd_tag   (w_rd_tag),
      .o_rd_target(w_rd_target),
      .o_rd_ctr   (w_rd_ctr),
      .o_valid    (valid)
   );

   assign w_tag_match    = w_rd_valid && (w_rd_tag == pc[PC_WIDTH-1:INDEX_WIDTH+2]);
   assign btbHit         = w_tag_match && (w_rd_ctr >= WEAK_T);
   assign btbPredictedPc = btbHit ? {w_rd_target, 2'b00} : '0;
endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed bench for branch_target_buffer with hand-computed expectations per scenario.
module tb_branch_target_buffer;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] pc = 32'h0;
   logic        btbHit;
   logic [31:0] btbPredictedPc;
   logic        updateEn = 1'b0;
   logic [31:0] updatePc = 32'h0;
   logic        updateTaken = 1'b0;
   logic [31:0] updateTarget = 32'h0;
   logic        flushAll = 1'b0;
   logic [15:0] valid;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   branch_target_buffer #(.PC_WIDTH(32), .ENTRY_NUM(16)) dut (
      .clk(clk), .rst(rst), .pc(pc), .btbHit(btbHit), .btbPredictedPc(btbPredictedPc),
      .updateEn(updateEn), .updatePc(updatePc), .updateTaken(updateTaken),
      .updateTarget(updateTarget), .flushAll(flushAll), .valid(valid)
   );

   task automatic do_update(input logic [31:0] a, input logic t, input logic [31:0] tgt);
      @(negedge clk);
      updateEn = 1'b1; updatePc = a; updateTaken = t; updateTarget = tgt;
      @(negedge clk);
      updateEn = 1'b0;
   endtask

   task automatic look(input logic [31:0] a);
      pc = a;
      #1;
   endtask

   task automatic test_reset;
      @(negedge clk);
      rst = 1'b0;
      #2 rst = 1'b1; pc = 32'h100;
      #1;
      checks++; if (btbHit !== 1'b0) begin failures++; $display("FAIL reset_hit got=%b exp=0", btbHit); end
      checks++; if (btbPredictedPc !== 32'h0) begin failures++; $display("FAIL reset_pred got=%h exp=0", btbPredictedPc); end
      checks++; if (valid !== 16'h0000) begin failures++; $display("FAIL reset_valid got=%h exp=0000", valid); end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_allocate;
      do_update(32'h100, 1'b1, 32'h200);
      look(32'h100);
      checks++; if (btbHit !== 1'b1) begin failures++; $display("FAIL alloc_hit got=%b exp=1", btbHit); end
      checks++; if (btbPredictedPc !== 32'h200) begin failures++; $display("FAIL alloc_pred got=%h exp=00000200", btbPredictedPc); end
      checks++; if (valid !== 16'h0001) begin failures++; $display("FAIL alloc_valid got=%h exp=0001", valid); end
      look(32'h140);
      checks++; if (btbHit !== 1'b0 || btbPredictedPc !== 32'h0) begin failures++; $display("FAIL alias_miss got=%b/%h exp=0/0", btbHit, btbPredictedPc); end
      do_update(32'h13F, 1'b1, 32'h88B);
      look(32'h13C);
      checks++; if (btbPredictedPc !== 32'h888 || valid !== 16'h8001) begin failures++; $display("FAIL top_index got=%h/%h exp=00000888/8001", btbPredictedPc, valid); end
   endtask

   task automatic test_training;
      do_update(32'h100, 1'b0, 32'h0);
      look(32'h100);
      checks++; if (btbHit !== 1'b0) begin failures++; $display("FAIL train_nt1 got=%b exp=0", btbHit); end
      do_update(32'h100, 1'b0, 32'h0);
      look(32'h100);
      checks++; if (btbHit !== 1'b0 || valid[0] !== 1'b1) begin failures++; $display("FAIL train_nt2 got=%b/%b exp=0/1", btbHit, valid[0]); end
      do_update(32'h100, 1'b0, 32'h0);
      do_update(32'h100, 1'b1, 32'h200);
      look(32'h100);
      checks++; if (btbHit !== 1'b0) begin failures++; $display("FAIL train_t1 got=%b exp=0", btbHit); end
      do_update(32'h100, 1'b1, 32'h200);
      look(32'h100);
      checks++; if (btbHit !== 1'b1 || btbPredictedPc !== 32'h200) begin failures++; $display("FAIL train_t2 got=%b/%h exp=1/00000200", btbHit, btbPredictedPc); end
   endtask

   task automatic test_saturation;
      for (int i = 0; i < 5; i++) do_update(32'h100, 1'b1, 32'h300);
      look(32'h100);
      checks++; if (btbPredictedPc !== 32'h300) begin failures++; $display("FAIL sat_retarget got=%h exp=00000300", btbPredictedPc); end
      do_update(32'h100, 1'b0, 32'h0);
      look(32'h100);
      checks++; if (btbHit !== 1'b1 || btbPredictedPc !== 32'h300) begin failures++; $display("FAIL sat_dec got=%b/%h exp=1/00000300", btbHit, btbPredictedPc); end
      for (int i = 0; i < 3; i++) do_update(32'h100, 1'b1, 32'h300);
      do_update(32'h100, 1'b0, 32'h0);
      look(32'h100);
      checks++; if (btbHit !== 1'b1) begin failures++; $display("FAIL sat_hold got=%b exp=1", btbHit); end
   endtask

   task automatic test_conflict;
      do_update(32'h140, 1'b0, 32'h999);
      look(32'h100);
      checks++; if (btbHit !== 1'b1 || btbPredictedPc !== 32'h300) begin failures++; $display("FAIL conflict_keep got=%b/%h exp=1/00000300", btbHit, btbPredictedPc); end
      do_update(32'h140, 1'b1, 32'h400);
      look(32'h140);
      checks++; if (btbHit !== 1'b1 || btbPredictedPc !== 32'h400) begin failures++; $display("FAIL conflict_new got=%b/%h exp=1/00000400", btbHit, btbPredictedPc); end
      look(32'h100);
      checks++; if (btbHit !== 1'b0) begin failures++; $display("FAIL conflict_evict got=%b exp=0", btbHit); end
   endtask

   task automatic test_back_to_back;
      do_update(32'h100, 1'b1, 32'h200);
      @(negedge clk);
      pc = 32'h100;
      updateEn = 1'b1; updatePc = 32'h100; updateTaken = 1'b1; updateTarget = 32'h500;
      #1;
      checks++; if (btbPredictedPc !== 32'h200) begin failures++; $display("FAIL same_cycle_old got=%h exp=00000200", btbPredictedPc); end
      @(negedge clk);
      updateEn = 1'b0;
      #1;
      checks++; if (btbPredictedPc !== 32'h500) begin failures++; $display("FAIL same_cycle_new got=%h exp=00000500", btbPredictedPc); end
      @(negedge clk);
      flushAll = 1'b1; updateEn = 1'b1; updatePc = 32'h204; updateTaken = 1'b1; updateTarget = 32'h600;
      @(negedge clk);
      flushAll = 1'b0; updateEn = 1'b0;
      look(32'h204);
      checks++; if (valid !== 16'h0000 || btbHit !== 1'b0) begin failures++; $display("FAIL flush got=%h/%b exp=0000/0", valid, btbHit); end
      do_update(32'h100, 1'b1, 32'h600);
      look(32'h100);
      checks++; if (btbPredictedPc !== 32'h600 || valid !== 16'h0001) begin failures++; $display("FAIL post_flush got=%h/%h exp=00000600/0001", btbPredictedPc, valid); end
   endtask

   task automatic test_reset_mid;
      @(negedge clk);
      updateEn = 1'b1; updatePc = 32'h204; updateTaken = 1'b1; updateTarget = 32'h800;
      @(posedge clk);
      #3 rst = 1'b1; pc = 32'h100;
      #1;
      checks++; if (btbHit !== 1'b0 || btbPredictedPc !== 32'h0 || valid !== 16'h0000) begin failures++; $display("FAIL mid_reset got=%b/%h/%h exp=0/0/0000", btbHit, btbPredictedPc, valid); end
      @(negedge clk);
      rst = 1'b0; updateEn = 1'b0;
      do_update(32'h100, 1'b1, 32'h700);
      look(32'h100);
      checks++; if (btbHit !== 1'b1 || btbPredictedPc !== 32'h700) begin failures++; $display("FAIL after_reset got=%b/%h exp=1/00000700", btbHit, btbPredictedPc); end
   endtask

   initial begin
      test_reset();
      test_allocate();
      test_training();
      test_saturation();
      test_conflict();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
